// File: rtl/alu_mc.sv
// Multi-cycle ALU: legacy 3-bit ops, barrel shifts, iterative multiply and optional divide.
// Define ALU_MC_DIV_EN to build the restoring divider (divu/remu); otherwise those codes are reserved.
module alu_mc #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             of,
    output logic             dz
);
    localparam int unsigned SW = $clog2(WIDTH);
    localparam int unsigned CW = SW + 1;
    localparam logic [CW-1:0] CntLoad = CW'(WIDTH);

    localparam logic [3:0] OpAnd  = 4'b0000;
    localparam logic [3:0] OpOr   = 4'b0001;
    localparam logic [3:0] OpAdd  = 4'b0010;
    localparam logic [3:0] OpSltu = 4'b0011;
    localparam logic [3:0] OpXor  = 4'b0100;
    localparam logic [3:0] OpNor  = 4'b0101;
    localparam logic [3:0] OpSub  = 4'b0110;
    localparam logic [3:0] OpSlt  = 4'b0111;
    localparam logic [3:0] OpSll  = 4'b1000;
    localparam logic [3:0] OpSrl  = 4'b1001;
    localparam logic [3:0] OpSra  = 4'b1010;
    localparam logic [3:0] OpMul  = 4'b1100;
    localparam logic [3:0] OpMulh = 4'b1101;
`ifdef ALU_MC_DIV_EN
    localparam logic [3:0] OpDivu = 4'b1110;
    localparam logic [3:0] OpRemu = 4'b1111;
`endif

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
    logic            sel_hi_q, sel_hi_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic            of_q, of_d, dz_q, dz_d;

    // Single-cycle datapath
    logic             sub_like, add_of, is_mul, start_long;
    logic [WIDTH-1:0] b_eff, sum, alu_res;
    logic             alu_of, alu_dz;
    logic [SW-1:0]    shamt;

    assign sub_like = (op == OpSub) || (op == OpSlt);
    assign b_eff    = sub_like ? ~b : b;
    assign sum      = a + b_eff + {{(WIDTH-1){1'b0}}, sub_like};
    assign add_of   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign shamt    = b[SW-1:0];
    assign is_mul   = (op == OpMul) || (op == OpMulh);

    always_comb begin
        alu_res = '0;
        alu_of  = 1'b0;
        alu_dz  = 1'b0;
        case (op)
            OpAnd:  alu_res = a & b;
            OpOr:   alu_res = a | b;
            OpXor:  alu_res = a ^ b;
            OpNor:  alu_res = ~(a | b);
            OpAdd, OpSub: begin
                alu_res = sum;
                alu_of  = add_of;
            end
            OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1]};
            OpSltu: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OpSll:  alu_res = a << shamt;
            OpSrl:  alu_res = a >> shamt;
            OpSra:  alu_res = $unsigned($signed(a) >>> shamt);
`ifdef ALU_MC_DIV_EN
            // Only reached with b==0; nonzero divisors go through the iterative path.
            OpDivu: begin
                alu_res = '1;
                alu_dz  = 1'b1;
            end
            OpRemu: begin
                alu_res = a;
                alu_dz  = 1'b1;
            end
`endif
            default: alu_res = '0;
        endcase
    end

    // Iterative step: {hi,lo} is the 2*WIDTH accumulator for both multiply and divide
    logic [WIDTH-1:0] mul_addend, step_hi, step_lo;
    logic [WIDTH:0]   mul_sum;

    assign mul_addend = lo_q[0] ? opb_q : '0;
    assign mul_sum    = {1'b0, hi_q} + {1'b0, mul_addend};

`ifdef ALU_MC_DIV_EN
    logic           div_q, div_d, is_div, div_ok;
    logic [WIDTH:0] rem_sh;

    assign is_div     = (op == OpDivu) || (op == OpRemu);
    assign start_long = is_mul || (is_div && (b != '0));
    assign rem_sh     = {hi_q, lo_q[WIDTH-1]};
    assign div_ok     = rem_sh >= {1'b0, opb_q};

    always_comb begin
        if (div_q) begin
            step_hi = div_ok ? (rem_sh[WIDTH-1:0] - opb_q) : rem_sh[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], div_ok};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end
`else
    assign start_long = is_mul;
    assign step_hi    = mul_sum[WIDTH:1];
    assign step_lo    = {mul_sum[0], lo_q[WIDTH-1:1]};
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opb_d    = opb_q;
        sel_hi_d = sel_hi_q;
        result_d = result_q;
        of_d     = of_q;
        dz_d     = dz_q;
`ifdef ALU_MC_DIV_EN
        div_d    = div_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (start_long) begin
                        state_d  = StBusy;
                        cnt_d    = CntLoad;
                        hi_d     = '0;
                        lo_d     = a;
                        opb_d    = b;
                        sel_hi_d = op[0];
`ifdef ALU_MC_DIV_EN
                        div_d    = is_div;
`endif
                    end else begin
                        state_d  = StDone;
                        result_d = alu_res;
                        of_d     = alu_of;
                        dz_d     = alu_dz;
                    end
                end
            end
            StBusy: begin
                cnt_d = cnt_q - CW'(1);
                hi_d  = step_hi;
                lo_d  = step_lo;
                if (cnt_q == CW'(1)) begin
                    // hi holds mulhu/remainder, lo holds mul/quotient
                    state_d  = StDone;
                    result_d = sel_hi_q ? step_hi : step_lo;
                    of_d     = 1'b0;
                    dz_d     = 1'b0;
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            sel_hi_q <= 1'b0;
            result_q <= '0;
            of_q     <= 1'b0;
            dz_q     <= 1'b0;
`ifdef ALU_MC_DIV_EN
            div_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opb_q    <= opb_d;
            sel_hi_q <= sel_hi_d;
            result_q <= result_d;
            of_q     <= of_d;
            dz_q     <= dz_d;
`ifdef ALU_MC_DIV_EN
            div_q    <= div_d;
`endif
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign of        = of_q;
    assign dz        = dz_q;

endmodule

// File: tb/tb_alu_mc.sv
// Randomized self-checking bench for alu_mc against an arithmetic reference model.
// Expected divide results follow ALU_MC_DIV_EN, as for the design.
module tb_alu_mc;
    localparam int W = 32;

`ifdef ALU_MC_DIV_EN
    localparam bit DivEn = 1'b1;
`else
    localparam bit DivEn = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   op = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         of;
    logic         dz;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .of        (of),
        .dz        (dz)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic v, output logic z);
        logic [63:0]  p;
        logic [W-1:0] s;
        r = '0;
        v = 1'b0;
        z = 1'b0;
        p = 64'(x) * 64'(y);
        case (o)
            4'h0: r = x & y;
            4'h1: r = x | y;
            4'h2: begin
                r = x + y;
                v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
            end
            4'h6: begin
                r = x - y;
                v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
            end
            4'h7: begin
                s = x - y;
                r = W'(s[W-1]);
            end
            4'h3: r = W'(x < y);
            4'h4: r = x ^ y;
            4'h5: r = ~(x | y);
            4'h8: r = x << y[4:0];
            4'h9: r = x >> y[4:0];
            4'hA: r = $unsigned($signed(x) >>> y[4:0]);
            4'hC: r = p[31:0];
            4'hD: r = p[63:32];
            4'hE: if (DivEn) begin
                if (y == 0) begin r = '1; z = 1'b1; end
                else r = x / y;
            end
            4'hF: if (DivEn) begin
                if (y == 0) begin r = x; z = 1'b1; end
                else r = x % y;
            end
            default: r = '0;
        endcase
    endfunction

    function automatic bit is_long(input logic [3:0] o, input logic [W-1:0] y);
        return (o == 4'hC) || (o == 4'hD) || (DivEn && (o[3:1] == 3'b111) && (y != 0));
    endfunction

    task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int bp);
        logic [W-1:0] er;
        logic         ev, ez;
        int           lat;
        bit           rdy_err;
        model(o, x, y, er, ev, ez);
        @(negedge clk);
        check({tag, " in_ready idle"}, 64'(in_ready), 64'(1));
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        op = 4'($urandom);
        lat = 0;
        rdy_err = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (in_ready) rdy_err = 1'b1;
        end while (!out_valid && lat < 200);
        check({tag, " latency"}, 64'(lat), 64'(is_long(o, y) ? W + 1 : 1));
        check({tag, " in_ready busy"}, 64'(rdy_err), 64'(0));
        check({tag, " result"}, 64'(result), 64'(er));
        check({tag, " of"}, 64'(of), 64'(ev));
        check({tag, " dz"}, 64'(dz), 64'(ez));
        repeat (bp) begin
            @(negedge clk);
            check({tag, " hold"}, {31'(0), out_valid, in_ready, result},
                  {31'(0), 1'b1, 1'b0, er});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, " handoff"}, {62'(0), in_ready, out_valid}, {62'(0), 1'b1, 1'b0});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]   ro;
        logic [W-1:0] rx, ry;
        #12;
        check("reset state", {29'(0), in_ready, out_valid, of, dz, result},
              {29'(0), 1'b1, 1'b0, 1'b0, 1'b0, 32'(0)});
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add ovf", 4'h2, 32'h7FFF_FFFF, 32'h1, 0);
        run_op("sub ovf", 4'h6, 32'h8000_0000, 32'h1, 0);
        run_op("mul", 4'hC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mulhu", 4'hD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("divu", 4'hE, 32'd100, 32'd7, 0);
        run_op("remu", 4'hF, 32'd100, 32'd7, 0);
        run_op("divu dz", 4'hE, 32'd5, 32'd0, 0);
        run_op("remu dz", 4'hF, 32'd5, 32'd0, 0);
        run_op("sra", 4'hA, 32'h8000_0000, 32'd36, 0);
        run_op("srl", 4'h9, 32'h8000_0000, 32'd36, 0);
        run_op("sltu", 4'h3, 32'h1, 32'hFFFF_FFFF, 0);
        run_op("slt", 4'h7, 32'h1, 32'hFFFF_FFFF, 0);
        run_op("reserved", 4'hB, 32'hDEAD_BEEF, 32'h1234_5678, 0);
        run_op("backpressure", 4'h4, 32'hA5A5_0F0F, 32'h0FF0_1234, 5);

        for (int i = 0; i < 60; i++) begin
            ro = 4'($urandom_range(0, 15));
            rx = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 1000)) : $urandom;
            if ($urandom_range(0, 5) == 0) ry = '0;
            else if ($urandom_range(0, 1) == 0) ry = 32'($urandom_range(1, 255));
            else ry = $urandom;
            run_op("random", ro, rx, ry, $urandom_range(0, 2));
        end

        // Leave a nonzero result behind so the abort visibly clears it
        run_op("mulhu pre", 4'hD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        @(negedge clk);
        op = 4'hC;
        a = 32'h1234_5678;
        b = 32'h9ABC_DEF0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort", {29'(0), in_ready, out_valid, of, dz, result},
              {29'(0), 1'b1, 1'b0, 1'b0, 1'b0, 32'(0)});
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after reset", 4'h0, 32'd3, 32'd5, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised ALU for the CPU execute stage, and the successor to the single-cycle combinational ALU. It keeps the eight legacy 3-bit operations with unchanged encodings and adds barrel shifts, an iterative shift-add multiplier and a restoring divider. All operand/result traffic uses valid/ready handshakes, so the pipeline can stall on long operations. Results are registered: single-cycle ops take one cycle, multiply and divide take WIDTH+1 cycles.

## Interface
- WIDTH, 32, datapath width; power of two, at least 8. Shift amount is the low log2(WIDTH) bits of b.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and op presented
- in_ready  output  1  block can accept an operation; high only in IDLE
- a, b  input  WIDTH  operands
- op  input  4  operation code
- out_valid  output  1  result registers valid
- out_ready  input  1  consumer takes the result
- result  output  WIDTH  registered result
- of  output  1  signed overflow; add/sub only, 0 for all other ops
- dz  output  1  divide by zero on divu/remu; 0 otherwise

## Operation
- Op encoding, with op[3]=0 identical to legacy:
  - 0000 and; 0001 or; 0010 add; 0110 sub.
  - 0111 slt signed (sign of a−b); 0011 sltu (a<b unsigned).
  - 0100 xor; 0101 nor.
  - 1000 sll; 1001 srl; 1010 sra.
  - 1100 mul (low WIDTH bits); 1101 mulhu (high WIDTH bits, unsigned).
  - 1110 divu; 1111 remu.
  - 1011 reserved: result 0, of 0, dz 0.
- Arithmetic and flags:
  - sub computes a + ~b + 1.
  - of = (a[MSB]==b'[MSB]) & (sum[MSB]!=a[MSB]), where b' is b or ~b.
  - slt and sltu results are zero-extended to WIDTH.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, in_valid & op not mul/div: compute, register result/of/dz, go to DONE.
  - IDLE, in_valid & op mul/mulhu/divu/remu with b≠0: latch operands, clear the 2·WIDTH accumulator, load counter = WIDTH, go to BUSY.
  - IDLE, divu/remu with b==0: go directly to DONE. Quotient = all ones, remainder = a, dz = 1.
  - BUSY: one shift-add or restore-subtract step per cycle, counter decrements. At counter==1 the step completes, the selected half is registered, and the FSM goes to DONE.
  - DONE: out_valid=1. result/of/dz stay stable until out_ready. On out_ready, go to IDLE.
- in_ready = (state==IDLE). No acceptance while BUSY or DONE. in_valid is ignored outside IDLE.
- Operands need only be stable during the accept cycle; the block latches them internally.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, result 0, of 0, dz 0, counter 0.
- Single-cycle ops and divide-by-zero: accept at edge N, out_valid high after edge N+1.
- mul/mulhu/divu/remu: out_valid high WIDTH+1 cycles after the accept edge (33 for WIDTH=32).
- Result handoff at the edge where out_valid & out_ready. in_ready rises the following cycle, giving a minimum issue interval of 2 cycles for single-cycle ops.
- Reset asserted mid-BUSY or in DONE: the operation is aborted and outputs return to reset values immediately. After deassertion the block is in IDLE and accepts on the first edge.
- out_ready held low: DONE persists indefinitely with no output change.

## Configuration
- ALU_MC_DIV_EN defined: the divider is compiled in and divu/remu behave as above.
- ALU_MC_DIV_EN undefined:
  - No divider logic is built.
  - 1110/1111 are treated as reserved: 1-cycle latency, result 0, dz 0.
  - Multiply is unaffected.

## Test plan
- add a=0x7FFFFFFF, b=1 → result 0x80000000, of=1, out_valid one cycle after accept; sub 0x80000000−1 → 0x7FFFFFFF, of=1.
- mul 0xFFFFFFFF×0xFFFFFFFF → 0x00000001; mulhu → 0xFFFFFFFE; out_valid exactly 33 cycles after accept; in_ready 0 throughout.
- divu 100/7 → 14, remu → 2 after 33 cycles; divu 5/0 → 0xFFFFFFFF, dz=1 in 1 cycle; remu 5/0 → 5, dz=1; without ALU_MC_DIV_EN, divu 100/7 → 0.
- sra 0x80000000 by b=36 → 0xF8000000 (amount 4); srl → 0x08000000; sltu 1<0xFFFFFFFF → 1; slt → 0.
- Backpressure: complete an op with out_ready low for 5 cycles → result/out_valid stable, in_ready 0; out_ready high → in_ready 1 the next cycle.
- Assert rst_n low during cycle 10 of a mul → out_valid 0 and result 0 immediately; after release, and 3 & 5 → 1.
